data_memory_responder: RTL and testbench

// - Handshaked data-memory responder: the memory end of the CPU load/store path.
// - Accepts one word-addressed read/write request on a valid/ready channel and

---
 rtl/data_memory_responder.sv | 124 ++++++++++++
 tb/tb_data_memory_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// data_memory_responder
//   Memory end of a multi-cycle CPU load/store path. One word-addressed
//   request is accepted on the req_* valid/ready channel. Its response is
//   returned LATENCY cycles later on the rsp_* valid/ready channel.
//
// Ports
//   clk             clock, all state on posedge
//   reset           synchronous, active-high; reloads memory from initial_values
//   initial_values  DEPTH x 32 power-up image of the memory
//   req_valid/ready request handshake (ready only while IDLE and not in reset)
//   req_addr        byte address; word index = req_addr[31:2]
//   req_we          1 = store, 0 = load
//   req_wstrb       per-byte write enables for stores
//   req_wdata       store data
//   rsp_valid/ready response handshake
//   rsp_rdata       load data (0 for stores and errors)
//   rsp_err         misaligned address or word index >= DEPTH
//   memory_check    live view of every memory word
module data_memory_responder #(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DEPTH-1:0][31:0] initial_values,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [31:0]            req_addr,
  input  logic                   req_we,
  input  logic [3:0]             req_wstrb,
  input  logic [31:0]            req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic [DEPTH-1:0][31:0] memory_check
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                 state;
  logic [3:0]             counter;
  logic [DEPTH-1:0][31:0] mem;

  logic [29:0]   idx;
  logic [AW-1:0] word;
  logic          addr_err;

  // The range check uses the full index, so large addresses never alias
  // onto low words. The truncated index is only used when the check passes.
  assign idx      = req_addr[31:2];
  assign word     = idx[AW-1:0];
  assign addr_err = (req_addr[1:0] != 2'b00) || (idx >= DEPTH_W);

  assign req_ready    = (state == S_IDLE) && !reset;
  assign memory_check = mem;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem       <= initial_values;
      state     <= S_IDLE;
      counter   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (addr_err) begin
              rsp_rdata <= '0;
              rsp_err   <= 1'b1;
            end else if (req_we) begin
              for (int unsigned b = 0; b < 4; b++) begin
                if (req_wstrb[b]) begin
                  mem[word][8*b +: 8] <= req_wdata[8*b +: 8];
                end
              end
              rsp_rdata <= '0;
              rsp_err   <= 1'b0;
            end else begin
              rsp_rdata <= mem[word];
              rsp_err   <= 1'b0;
            end
            counter <= 4'(LATENCY - 1);
            state   <= (LATENCY == 1) ? S_RESP : S_WAIT;
          end
        end

        S_WAIT: begin
          counter <= counter - 4'd1;
          if (counter == 4'd1) begin
            state <= S_RESP;
          end
        end

        S_RESP: begin
          // rsp_valid is raised on the first edge spent in RESP. With the
          // state reached at edge N+LATENCY-1, it rises at edge N+LATENCY.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Testbench for data_memory_responder. Two instances (LATENCY 2 and 1)
// receive identical stimulus. A reference model computes expected responses
// at accept time and pushes them into per-instance queues. A negedge monitor
// pops an entry and compares it whenever a response appears.
module tb_data_memory_responder;

  localparam int unsigned DEPTH = 32;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    int unsigned due;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [DEPTH-1:0][31:0] init_vals;
  logic                   req_valid;
  logic [31:0]            req_addr;
  logic                   req_we;
  logic [3:0]             req_wstrb;
  logic [31:0]            req_wdata;
  logic                   rsp_ready;

  logic [1:0]             req_ready_v;
  logic [1:0]             rsp_valid_v;
  logic [1:0]             rsp_err_v;
  logic [31:0]            rsp_rdata_v [2];
  logic [DEPTH-1:0][31:0] mc_v [2];

  logic [DEPTH-1:0][31:0] model_mem;
  exp_t                   sbq [2][$];
  int unsigned            cyc = 0;
  int unsigned            compared = 0;
  int unsigned            failed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_memory_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut_l2 (
    .clk(clk), .reset(reset), .initial_values(init_vals),
    .req_valid(req_valid), .req_ready(req_ready_v[0]), .req_addr(req_addr),
    .req_we(req_we), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_v[0]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_v[0]),
    .rsp_err(rsp_err_v[0]), .memory_check(mc_v[0])
  );

  data_memory_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset), .initial_values(init_vals),
    .req_valid(req_valid), .req_ready(req_ready_v[1]), .req_addr(req_addr),
    .req_we(req_we), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_v[1]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_v[1]),
    .rsp_err(rsp_err_v[1]), .memory_check(mc_v[1])
  );

  function automatic int unsigned lat_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  // ---------------- monitor ----------------
  logic [1:0]  seen = 2'b00;
  logic [31:0] held_rdata [2];
  logic        held_err [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        seen[d] = 1'b0;
      end else if (rsp_valid_v[d]) begin
        if (!seen[d]) begin
          compared++;
          if (sbq[d].size() == 0) begin
            failed++;
            $display("FAIL unexpected_rsp dut%0d: rsp_valid=1 rdata=%h err=%b, required no response", d, rsp_rdata_v[d], rsp_err_v[d]);
          end else begin
            exp_t e;
            e = sbq[d].pop_front();
            if (rsp_rdata_v[d] !== e.rdata || rsp_err_v[d] !== e.err || cyc != e.due) begin
              failed++;
              $display("FAIL rsp dut%0d: rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                       d, rsp_rdata_v[d], rsp_err_v[d], cyc, e.rdata, e.err, e.due);
            end
          end
          seen[d]       = 1'b1;
          held_rdata[d] = rsp_rdata_v[d];
          held_err[d]   = rsp_err_v[d];
        end else begin
          compared++;
          if (rsp_rdata_v[d] !== held_rdata[d] || rsp_err_v[d] !== held_err[d]) begin
            failed++;
            $display("FAIL rsp_stable dut%0d: rdata=%h err=%b, required rdata=%h err=%b",
                     d, rsp_rdata_v[d], rsp_err_v[d], held_rdata[d], held_err[d]);
          end
        end
        if (rsp_ready) seen[d] = 1'b0;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_mem(input string name);
    for (int d = 0; d < 2; d++) begin
      int bad_i;
      bad_i = -1;
      for (int i = 0; i < DEPTH; i++) begin
        if (bad_i < 0 && mc_v[d][i] !== model_mem[i]) bad_i = i;
      end
      compared++;
      if (bad_i >= 0) begin
        failed++;
        $display("FAIL %s dut%0d: mem[%0d]=%h, required %h", name, d, bad_i, mc_v[d][bad_i], model_mem[bad_i]);
      end
    end
  endtask

  task automatic wait_idle(input bit random_ready);
    int n;
    n = 0;
    while (!(req_ready_v == 2'b11 && rsp_valid_v == 2'b00) && n < 100) begin
      rsp_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    rsp_ready = 1'b1;
    compared++;
    if (n >= 100 || sbq[0].size() != 0 || sbq[1].size() != 0) begin
      failed++;
      $display("FAIL idle dut: req_ready=%b rsp_valid=%b pending=%0d/%0d, required ready=11 valid=00 pending=0/0",
               req_ready_v, rsp_valid_v, sbq[0].size(), sbq[1].size());
    end
  endtask

  // Both instances must be idle on entry; the request is accepted at the next edge.
  task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] strb, input logic [31:0] wdata);
    exp_t        e;
    int unsigned idx;
    logic        bad;
    req_valid = 1'b1;
    req_addr  = addr;
    req_we    = we;
    req_wstrb = strb;
    req_wdata = wdata;
    idx = addr >> 2;
    bad = (addr % 4 != 0) || (idx >= DEPTH);
    e.err   = bad;
    e.rdata = (bad || we) ? 32'h0 : model_mem[idx];
    if (!bad && we) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    for (int d = 0; d < 2; d++) begin
      e.due = cyc + 1 + lat_of(d);
      sbq[d].push_back(e);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    reset     = 1'b1;
    req_valid = 1'b0;
    sbq[0].delete();
    sbq[1].delete();
    model_mem = init_vals;
    repeat (cycles) tick();
    compared++;
    if (req_ready_v !== 2'b00 || rsp_valid_v !== 2'b00 || rsp_err_v !== 2'b00 ||
        rsp_rdata_v[0] !== 32'h0 || rsp_rdata_v[1] !== 32'h0) begin
      failed++;
      $display("FAIL reset_outputs: req_ready=%b rsp_valid=%b err=%b rdata=%h/%h, required all 0",
               req_ready_v, rsp_valid_v, rsp_err_v, rsp_rdata_v[0], rsp_rdata_v[1]);
    end
    reset = 1'b0;
    #1;
    compared++;
    if (req_ready_v !== 2'b11) begin
      failed++;
      $display("FAIL ready_after_reset: req_ready=%b, required 11", req_ready_v);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_we    = 1'b0;
    req_wstrb = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) init_vals[i] = $urandom;
    init_vals[3] = 32'hDEADBEEF;
    do_reset(3);
    check_mem("mem_after_reset");
    for (int d = 0; d < 2; d++) begin
      compared++;
      if (mc_v[d][3] !== 32'hDEADBEEF) begin
        failed++;
        $display("FAIL mem3_init dut%0d: %h, required deadbeef", d, mc_v[d][3]);
      end
    end

    // Load, strobed store, error cases.
    issue(32'h0000_000C, 1'b0, 4'h0, 32'h0);
    wait_idle(0);
    issue(32'h0000_000C, 1'b1, 4'b0101, 32'h1122_3344);
    wait_idle(0);
    for (int d = 0; d < 2; d++) begin
      compared++;
      if (mc_v[d][3] !== 32'hDE22BE44) begin
        failed++;
        $display("FAIL mem3_store dut%0d: %h, required de22be44", d, mc_v[d][3]);
      end
    end
    issue(32'h0000_000D, 1'b0, 4'h0, 32'h0);
    wait_idle(0);
    issue(32'h0000_0080, 1'b0, 4'h0, 32'h0);
    wait_idle(0);
    issue(32'h0000_0081, 1'b1, 4'hF, 32'hFFFF_FFFF);
    wait_idle(0);
    issue(32'h0000_0010, 1'b1, 4'h0, 32'hA5A5_A5A5);
    wait_idle(0);
    check_mem("mem_after_directed");

    // Backpressure with an ignored second request.
    rsp_ready = 1'b0;
    issue(32'h0000_000C, 1'b0, 4'h0, 32'h0);
    n = 0;
    while (rsp_valid_v != 2'b11 && n < 20) begin
      tick();
      n++;
    end
    compared++;
    if (n >= 20) begin
      failed++;
      $display("FAIL bp_rsp_timeout: rsp_valid=%b, required 11", rsp_valid_v);
    end
    req_valid = 1'b1;
    req_addr  = 32'h0;
    req_we    = 1'b1;
    req_wstrb = 4'hF;
    req_wdata = 32'h0BAD_F00D;
    repeat (5) begin
      tick();
      compared++;
      if (req_ready_v !== 2'b00 || rsp_valid_v !== 2'b11) begin
        failed++;
        $display("FAIL bp_hold: req_ready=%b rsp_valid=%b, required 00 and 11", req_ready_v, rsp_valid_v);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle(0);
    check_mem("mem_after_backpressure");

    // Reset while a store is in flight: nothing delivered, memory reloaded.
    issue(32'h0000_0014, 1'b1, 4'hF, 32'h1234_5678);
    init_vals[5] = 32'hCAFE_0005;
    do_reset(2);
    repeat (6) tick();
    wait_idle(0);
    check_mem("mem_after_mid_reset");

    // Randomized traffic with random response backpressure.
    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 7)       a = {25'h0, 5'($urandom_range(0, DEPTH - 1)), 2'b00};
      else if (r == 7) a = {25'h0, 5'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
      else if (r == 8) a = {24'h0, 6'($urandom_range(DEPTH, 63)), 2'b00};
      else             a = $urandom | 32'h8000_0000;
      issue(a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
      wait_idle(1);
      if (t % 25 == 24) check_mem("mem_random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
